mem_stage_pipe: RTL
===================

Name: mem_stage_pipe

Overview:
Parametrised memory-access pipeline stage with the MEM/WB register built in. Sits between the execute stage and write-back of the RV32 pipeline. Relative to the fixed word-only memory stage, it adds:
- byte/halfword/word loads and stores selected by funct3, with sign or zero extension on loads;
- a configurable number of memory wait states, handled by an FSM and a stall output;
- a flush input;
- misaligned-access detection.

Parameters:
XLEN, 32, datapath width (only 32 supported)
DEPTH_WORDS, 1024, data memory depth in 32-bit words (power of two)
WAIT_STATES, 0, extra cycles per load/store (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
valid_m  input  1  instruction present in M stage
RegWriteM  input  1  register write enable
MemWriteM  input  1  store
MemReadM  input  1  load
ResultSrcM  input  1  write-back select (1 = load data)
funct3_m  input  3  access size/sign
RD_M  input  5  destination register
PCPlus4M  input  32  PC+4
WriteDataM  input  32  store data (rs2)
ALU_ResultM  input  32  effective address / ALU result
flush_m  input  1  discard M-stage instruction
stall_m  output  1  hold upstream stages
valid_w  output  1  W-stage instruction valid
RegWriteW  output  1  register write enable to W
ResultSrcW  output  1  write-back select to W
RD_W  output  5  destination register to W
PCPlus4W  output  32  PC+4 to W
ALU_ResultW  output  32  ALU result to W
ReadDataW  output  32  extended load data
misalign_w  output  1  W instruction was a misaligned access

Behaviour:
- Reset: rst low asynchronously clears all W outputs, misalign_w and the FSM (to IDLE, counter 0). stall_m is 0 during reset. Memory contents are not reset.
- Memory addressing: word index = ALU_ResultM[log2(DEPTH_WORDS)+1:2]; upper bits ignored (address wraps modulo memory size). Byte-enable writes.
- Load extension by funct3: 000 LB sign-extends, 100 LBU zero-extends, 001 LH sign-extends, 101 LHU zero-extends, 010 LW. Lane is chosen by addr[1:0] (little-endian).
- Store width by funct3: 000 SB, 001 SH, 010 SW; store data is taken from the low bits of WriteDataM. Any other funct3 on a memory op is treated as a word access.
- Access = valid_m & (MemReadM | MemWriteM).
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM states:
  - IDLE: if access, not misaligned, not flushed and WAIT_STATES>0, assert stall_m, load counter with WAIT_STATES-1, and go to BUSY at the next edge. Otherwise the instruction completes at this edge.
  - BUSY: stall_m = 1 while counter≠0; counter decrements each cycle. When counter=0, stall_m = 0, the instruction completes at this edge, and the FSM returns to IDLE.
- Upstream holds all M inputs stable while stall_m=1.
- Completion edge:
  - the store, if any, is written exactly once;
  - the MEM/WB register captures all fields;
  - ReadDataW gets the extended data read at the completion address;
  - valid_w = valid_m.
- On any edge that is not a completion (stalling), the MEM/WB register loads a bubble: valid_w=0, RegWriteW=0, misalign_w=0; other fields are don't-care, and the model holds them at 0.
- Non-memory ops and bubbles complete in 1 cycle with no stall. WAIT_STATES=0 gives 1-cycle latency for all ops.
- Flush: flush_m=1 in IDLE or BUSY aborts the access. No write occurs, the next edge loads a bubble, the FSM goes to IDLE, and stall_m drops the same cycle (combinational on flush_m).
- Reset mid-BUSY: FSM goes to IDLE and the store is not performed.

Optional Feature:
MEM_MISALIGN_TRAP_EN:
- Defined: a misaligned access completes immediately with no wait states. A store is suppressed; a load returns 0. RegWriteW=0 and misalign_w=1 for that instruction.
- Undefined: addr low bits are forced to alignment (halfword clears bit 0, word clears bits 1:0), the access proceeds normally, and misalign_w is tied 0.

Test Plan:
1. Assert rst low mid-run → all W outputs 0, stall_m 0; release, then issue an ALU op with ALU_ResultM=0x55 and RD_M=7 → one edge later valid_w=1, ALU_ResultW=0x55, RD_W=7.
2. WAIT_STATES=0: SW 0xDEADBEEF to 0x10. Then:
   - LB 0x13 → ReadDataW=0xFFFFFFDE;
   - LBU 0x13 → 0x000000DE;
   - LH 0x12 → 0xFFFFDEAD;
   - SB 0x7F to 0x11, then LW 0x10 → 0xDEAD7FEF.
3. WAIT_STATES=2, LW 0x10 → stall_m=1 for 2 cycles, valid_w=1 with data on the 3rd edge; bubbles (valid_w=0) on the preceding edges.
4. WAIT_STATES=2, SW 0x12345678 to 0x20 with flush_m=1 in the 2nd cycle → stall_m drops, bubble at W; a later LW 0x20 returns the old value.
5. With MEM_MISALIGN_TRAP_EN: SH 0xAAAA to 0x21 → misalign_w=1, RegWriteW=0, memory unchanged, no stall. Without the macro: same stimulus writes 0xAAAA to 0x20.
6. WAIT_STATES=3: SW to 0x30, rst pulsed low during BUSY → FSM in IDLE, stall_m=0, word at 0x30 unchanged.

Source files
------------

// File: rtl/mem_stage_if.sv
// M-stage to W-stage signal bundle for mem_stage_pipe.
// master drives the M-stage instruction and reads the W register; slave is the stage itself.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_m;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            MemReadM;
    logic            ResultSrcM;
    logic [2:0]      funct3_m;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] ALU_ResultM;
    logic            flush_m;

    logic            stall_m;
    logic            valid_w;
    logic            RegWriteW;
    logic            ResultSrcW;
    logic [4:0]      RD_W;
    logic [XLEN-1:0] PCPlus4W;
    logic [XLEN-1:0] ALU_ResultW;
    logic [XLEN-1:0] ReadDataW;
    logic            misalign_w;

    modport master (
        output valid_m, RegWriteM, MemWriteM, MemReadM, ResultSrcM, funct3_m, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM, flush_m,
        input  stall_m, valid_w, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, misalign_w
    );

    modport slave (
        input  valid_m, RegWriteM, MemWriteM, MemReadM, ResultSrcM, funct3_m, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM, flush_m,
        output stall_m, valid_w, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, misalign_w
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// RV32 memory-access stage with built-in MEM/WB register, sub-word loads/stores and wait states.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of force-aligned.
module mem_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
    localparam logic       HAS_WAIT  = (WAIT_STATES > 0);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic            stall, complete;
    size_t           size;
    logic            access, misaligned, trap;
    logic [1:0]      addr_lo;
    logic [AW-1:0]   word_idx;
    logic [XLEN-1:0] rdata, shifted, load_data, store_data;
    logic [3:0]      be;
    logic            sign_bit, we;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    assign access   = bus.valid_m & (bus.MemReadM | bus.MemWriteM);
    assign word_idx = bus.ALU_ResultM[AW+1:2];
    assign rdata    = mem[word_idx];

    // funct3[1:0] selects width; anything beyond halfword is handled as a word
    always_comb begin
        case (bus.funct3_m[1:0])
            2'b00:   size = SZ_B;
            2'b01:   size = SZ_H;
            default: size = SZ_W;
        endcase
    end

    assign misaligned = access & (((size == SZ_H) & bus.ALU_ResultM[0]) |
                                  ((size == SZ_W) & (bus.ALU_ResultM[1:0] != 2'b00)));

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        addr_lo = bus.ALU_ResultM[1:0];
        if (size == SZ_H) addr_lo[0] = 1'b0;
        if (size == SZ_W) addr_lo     = 2'b00;
    end

    // Load lane select (little-endian) and extension; funct3[2] marks unsigned
    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        sign_bit = 1'b0;
        case (size)
            SZ_B: begin
                sign_bit  = shifted[7] & ~bus.funct3_m[2];
                load_data = {{(XLEN-8){sign_bit}}, shifted[7:0]};
            end
            SZ_H: begin
                sign_bit  = shifted[15] & ~bus.funct3_m[2];
                load_data = {{(XLEN-16){sign_bit}}, shifted[15:0]};
            end
            default: load_data = shifted;
        endcase
        if (trap) load_data = '0;
    end

    always_comb begin
        case (size)
            SZ_B: begin
                store_data = {4{bus.WriteDataM[7:0]}};
                be         = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                store_data = {2{bus.WriteDataM[15:0]}};
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = bus.WriteDataM;
                be         = 4'b1111;
            end
        endcase
    end

    // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stall    = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (access & ~trap & ~bus.flush_m & HAS_WAIT) begin
                    stall   = 1'b1;
                    state_n = BUSY;
                    cnt_n   = WAIT_LOAD;
                end else begin
                    complete = ~bus.flush_m;
                end
            end
            BUSY: begin
                if (bus.flush_m) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == 4'd0) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.stall_m = stall & rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Gating with rst keeps a store from landing on an edge while reset is held
    assign we = complete & bus.valid_m & bus.MemWriteM & ~trap & rst;

    // NOTE: the data array has no reset; contents survive rst, only control state is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid_w     <= 1'b0;
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= '0;
            bus.PCPlus4W    <= '0;
            bus.ALU_ResultW <= '0;
            bus.ReadDataW   <= '0;
            bus.misalign_w  <= 1'b0;
        end else if (complete) begin
            bus.valid_w     <= bus.valid_m;
            bus.RegWriteW   <= bus.RegWriteM & ~trap;
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.PCPlus4W    <= bus.PCPlus4M;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            bus.ReadDataW   <= load_data;
            bus.misalign_w  <= trap;
        end else begin
            bus.valid_w     <= 1'b0;
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= '0;
            bus.PCPlus4W    <= '0;
            bus.ALU_ResultW <= '0;
            bus.ReadDataW   <= '0;
            bus.misalign_w  <= 1'b0;
        end
    end
endmodule
